// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one Adder between N operand requesters,
// keeping one operation in flight and returning its result tagged by requester id.
module adder_arbiter #(
    parameter int N       = 4,
    parameter int W       = 4,
    parameter int LAT     = 1,
    parameter int TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req_valid,
    input  logic [N*W-1:0]     req_a,
    input  logic [N*W-1:0]     req_b,
    output logic [N-1:0]       req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2:0]         rsp_id,
    output logic [2*W+1:0]     rsp_data,
    output logic               rsp_err,
    output logic               busy,
    output logic [15:0]        done_count,
    output logic [W-1:0]       add_a,
    output logic [W-1:0]       add_b,
    input  logic               adder_guard,
    input  logic [2*W+1:0]     adder_res
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    logic [2:0]        r_last_grant;
    logic [3:0]        r_cnt;
    logic [7:0]        r_tcnt;
    logic [W-1:0]      r_add_a;
    logic [W-1:0]      r_add_b;
    logic              r_rsp_valid;
    logic [2:0]        r_rsp_id;
    logic [2*W+1:0]    r_rsp_data;
    logic              r_rsp_err;
    logic [15:0]       r_done_count;

    logic [W-1:0]      w_a [N];
    logic [W-1:0]      w_b [N];
    logic              w_found;
    logic [2:0]        w_gnt_idx;
    logic [W-1:0]      w_sel_a;
    logic [W-1:0]      w_sel_b;

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign w_a[gi] = req_a[gi*W +: W];
        assign w_b[gi] = req_b[gi*W +: W];
    end

    // Two passes give the wrap-around scan: first above last_grant, then from 0.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && req_valid[i] && (i > int'(r_last_grant))) begin
                w_found   = 1'b1;
                w_gnt_idx = 3'(i);
                w_sel_a   = w_a[i];
                w_sel_b   = w_b[i];
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!w_found && req_valid[i] && (i <= int'(r_last_grant))) begin
                w_found   = 1'b1;
                w_gnt_idx = 3'(i);
                w_sel_a   = w_a[i];
                w_sel_b   = w_b[i];
            end
        end
    end

    assign req_ready  = (rst_n && (r_state == S_IDLE) && w_found)
                        ? ({{(N-1){1'b0}}, 1'b1} << w_gnt_idx) : '0;
    assign busy       = (r_state != S_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;
    assign rsp_err    = r_rsp_err;
    assign done_count = r_done_count;
    assign add_a      = r_add_a;
    assign add_b      = r_add_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 3'(N-1);
            r_cnt        <= '0;
            r_tcnt       <= '0;
            r_add_a      <= '0;
            r_add_b      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_done_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_add_a      <= w_sel_a;
                        r_add_b      <= w_sel_b;
                        r_rsp_id     <= w_gnt_idx;
                        r_last_grant <= w_gnt_idx;
                        r_cnt        <= 4'(LAT);
                        r_tcnt       <= '0;
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (adder_guard) begin
                        r_rsp_data  <= adder_res;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_tcnt == 8'(TIMEOUT-1)) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid  <= 1'b0;
                        r_done_count <= r_done_count + 16'd1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a transaction-level reference model
// checked every negedge plus literal per-transaction expectations.
module tb_adder_arbiter;
    localparam int N = 4, W = 4, LAT = 1, TIMEOUT = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid, rsp_ready;
    logic [2:0]     rsp_id;
    logic [9:0]     rsp_data;
    logic           rsp_err, busy;
    logic [15:0]    done_count;
    logic [W-1:0]   add_a, add_b;
    logic           adder_guard;
    logic [9:0]     adder_res;
    logic           guard_en;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.N(N), .W(W), .LAT(LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .done_count(done_count), .add_a(add_a), .add_b(add_b),
        .adder_guard(adder_guard), .adder_res(adder_res)
    );

    // Adder stand-in: result is the operands concatenated
    assign adder_guard = guard_en;
    assign adder_res   = {2'b00, add_a, add_b};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx = (last + k) % N;
            if (v[idx]) return N'(1) << idx;
        end
        return '0;
    endfunction

    // Reference model: phase 0 idle, 1 operation in flight, 2 response pending
    int          m_phase, m_last, m_el, m_id, m_done;
    logic [9:0]  m_data;
    logic        m_err;
    logic [3:0]  m_adda, m_addb;

    always @(negedge clk) begin
        logic [N-1:0] er;
        if (!rst_n) begin
            m_phase = 0; m_last = N-1; m_el = 0; m_id = 0; m_done = 0;
            m_data = '0; m_err = 1'b0; m_adda = '0; m_addb = '0;
        end
        er = (rst_n && m_phase == 0) ? rr_pick(req_valid, m_last) : '0;
        chk("m_req_ready", 32'(req_ready), 32'(er));
        chk("m_busy", 32'(busy), 32'(m_phase != 0));
        chk("m_rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
        chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
        chk("m_rsp_data", 32'(rsp_data), 32'(m_data));
        chk("m_rsp_err", 32'(rsp_err), 32'(m_err));
        chk("m_done_count", 32'(done_count), 32'(m_done & 16'hFFFF));
        chk("m_add_a", 32'(add_a), 32'(m_adda));
        chk("m_add_b", 32'(add_b), 32'(m_addb));
        if (rst_n) begin
            case (m_phase)
                0: if (er != '0) begin
                    for (int i = 0; i < N; i++) if (er[i]) m_id = i;
                    m_last = m_id;
                    m_adda = req_a[m_id*W +: W];
                    m_addb = req_b[m_id*W +: W];
                    m_el = 0;
                    m_phase = 1;
                end
                1: begin
                    m_el++;
                    if (m_el >= LAT + 1 && adder_guard) begin
                        m_data = {2'b00, m_adda, m_addb}; m_err = 1'b0; m_phase = 2;
                    end else if (m_el == LAT + TIMEOUT) begin
                        m_data = '0; m_err = 1'b1; m_phase = 2;
                    end
                end
                default: if (rsp_ready) begin
                    m_phase = 0; m_done++;
                end
            endcase
        end
    end

    task automatic op(input logic [3:0] v, input logic [3:0] exp_rdy, input int exp_lat,
                      input logic [2:0] exp_id, input logic [9:0] exp_data,
                      input logic exp_err, input int bp, input int exp_done);
        int n;
        req_valid = v;
        rsp_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 50) begin @(negedge clk); n++; end
        chk("accept_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk); #1;
        n = 0;
        while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("rsp_latency", n, exp_lat);
        chk("rsp_id", 32'(rsp_id), 32'(exp_id));
        chk("rsp_data", 32'(rsp_data), 32'(exp_data));
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        req_valid = 4'b1111;
        for (int c = 0; c < bp; c++) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(rsp_data), 32'(exp_data));
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = v;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = '0;
        chk("hs_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("hs_done_count", 32'(done_count), 32'(exp_done));
        $display("op valid=%b id=%0d data=%h err=%0d lat=%0d done=%0d",
                 v, rsp_id, rsp_data, rsp_err, exp_lat, done_count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; guard_en = 1'b1;
        req_a = {4'hA, 4'h7, 4'h1, 4'h3};
        req_b = {4'h2, 4'hC, 4'h9, 4'h5};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_done", 32'(done_count), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        op(4'b0001, 4'b0001, 2, 3'd0, 10'h035, 1'b0, 0, 1);
        op(4'b1111, 4'b0010, 2, 3'd1, 10'h019, 1'b0, 0, 2);
        op(4'b1111, 4'b0100, 2, 3'd2, 10'h07C, 1'b0, 0, 3);
        op(4'b1111, 4'b1000, 2, 3'd3, 10'h0A2, 1'b0, 0, 4);
        op(4'b1111, 4'b0001, 2, 3'd0, 10'h035, 1'b0, 0, 5);
        op(4'b0100, 4'b0100, 2, 3'd2, 10'h07C, 1'b0, 0, 6);
        op(4'b0101, 4'b0001, 2, 3'd0, 10'h035, 1'b0, 0, 7);
        guard_en = 1'b0;
        op(4'b0010, 4'b0010, 9, 3'd1, 10'h000, 1'b1, 0, 8);
        guard_en = 1'b1;
        op(4'b1000, 4'b1000, 2, 3'd3, 10'h0A2, 1'b0, 5, 9);

        // Abandon an operation with an asynchronous reset pulse mid-WAIT
        req_valid = 4'b0100;
        @(negedge clk);
        chk("ar_accept", 32'(req_ready), 32'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        chk("ar_busy_before", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("ar_done", 32'(done_count), 32'd0);
        chk("ar_add_a", 32'(add_a), 32'd0);
        chk("ar_rsp_id", 32'(rsp_id), 32'd0);
        $display("async reset asserted busy=%0d done=%0d", busy, done_count);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            chk("ar_no_rsp", 32'(rsp_valid), 32'd0);
        end
        op(4'b1111, 4'b0001, 2, 3'd0, 10'h035, 1'b0, 0, 1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
